axi4_deinterleaver_pq: RTL and testbench
========================================

Name: axi4_deinterleaver_pq

Overview:
- Parametrised successor to the single-queue AXI4 read deinterleaver; sits between a TileLink-to-AXI4 bridge (master side, "in") and an AXI4 slave/crossbar (slave side, "out").
- Buffers R beats per ID, releases each burst to the master only once it is complete, and never interleaves bursts.
- Gates AR issue with per-ID beat credits so the buffers cannot overflow.
- AR payload fields other than id/len, and AW/W/B, are wired straight through by the enclosing wrapper and are outside this block.

Parameters:
- ID_BITS, 3, AXI ID width; NIDS = 2^ID_BITS per-ID queues.
- DATA_BITS, 64, R data width.
- ECHO_BITS, 7, packed R echo width ({tl_state_size[3:0], tl_state_source[2:0]}).
- BEATS, 4, per-ID queue depth in beats; also the maximum outstanding beats per ID.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- auto_in_arvalid  in  1  master AR valid.
- auto_in_arready  out  1  AR ready to master.
- auto_in_arid  in  ID_BITS  AR id.
- auto_in_arlen  in  8  AR len (beats-1).
- auto_out_arvalid  out  1  AR valid to slave.
- auto_out_arready  in  1  slave AR ready.
- auto_out_rvalid  in  1  slave R valid.
- auto_out_rready  out  1  R ready to slave.
- auto_out_rid  in  ID_BITS  slave R id.
- auto_out_rdata  in  DATA_BITS  slave R data.
- auto_out_recho  in  ECHO_BITS  slave R echo.
- auto_out_rlast  in  1  slave R last.
- auto_in_rvalid  out  1  R valid to master.
- auto_in_rready  in  1  master R ready.
- auto_in_rid  out  ID_BITS  R id.
- auto_in_rdata  out  DATA_BITS  R data.
- auto_in_recho  out  ECHO_BITS  R echo.
- auto_in_rlast  out  1  R last.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: all queues empty; res[i]=0 and pend[i]=0 for every ID; FSM=IDLE; rr_ptr=NIDS-1.
- Reset outputs: while reset is high, auto_in_arready, auto_out_arvalid, auto_out_rready and auto_in_rvalid are 0.
- Reset mid-operation: all buffered beats are discarded, with no partial output.
- AR credit check, per ID i: res[i] counts beats reserved (outstanding plus buffered).
  - ok = res[arid] + arlen + 1 <= BEATS, computed at ID_BITS-independent width 9 bits, no wrap.
  - auto_out_arvalid = arvalid & ok; auto_in_arready = arready & ok (combinational).
  - On AR fire: res[arid] += arlen+1.
  - On each R beat delivered to the master: res[rid] -= 1.
  - If both happen on the same ID in one cycle, the net update is applied.
  - arlen+1 > BEATS never issues (held off forever); the bench asserts this never occurs.
- R enqueue: auto_out_rready=1 outside reset. Each beat is pushed into queue[rid] as {data, echo, last}.
  - A push to a full queue is a protocol violation: assertion fires, beat is dropped.
  - A last-beat push increments pend[rid] (completed bursts buffered).
- Arbiter FSM:
  - IDLE: if any pend[i]>0, select the first such i searching rr_ptr+1 upward with wrap; register lock_id=i and rr_ptr=i; go to LOCKED. auto_in_rvalid=0 in IDLE.
  - LOCKED: auto_in_rvalid = queue[lock_id] non-empty; auto_in_r* = head of queue[lock_id]; auto_in_rid = lock_id.
  - LOCKED, on fire: pop.
  - LOCKED, on fire with last: pend[lock_id] -= 1 and return to IDLE.
  - LOCKED never switches ID mid-burst regardless of other pends.
- Simultaneous last-push and last-pop on one ID: pend unchanged.
- Handshake rules: rvalid is never retracted without fire; payload is stable while rvalid & !rready.
- Latency: last beat accepted in cycle t, idle arbiter → auto_in_rvalid high in cycle t+2. One bubble cycle (IDLE) between consecutive bursts.

Test Plan:
- Single burst: AR id=2 len=3 → res[2]=4; 4 beats D0..D3 on out R, last on D3 at cycle t → in R presents D0..D3 from t+2 with rready=1, rlast on D3, res[2]=0 after.
- Interleave: id1 and id5 beats alternate A0,B0,A1(last),B1(last) → master sees A0,A1 then (one bubble) B0,B1; rid 1 then 5.
- Credit: BEATS=4, AR id3 len3 accepted; AR id3 len0 held with arready=0 until first id3 beat delivered to master, accepted in that same cycle.
- Round-robin: complete single-beat bursts buffered on ids 0,4,7 simultaneously, rr_ptr=NIDS-1 → served 0,4,7; new burst on 0 while 7 served → next grant 0.
- Backpressure: rready=0 for 5 cycles mid-burst on id1 while id6 completes → rvalid held, data stable, id1 burst finishes before id6.
- Reset mid-burst: assert reset 1 cycle during LOCKED → next cycle rvalid=0, all res/pend 0, fresh AR id0 len0 accepted immediately.

Source files
------------

// File: rtl/axi4_deinterleaver_pq.sv
// AXI4 read deinterleaver with per-ID beat queues.
//
// R beats arriving from the slave are buffered per ID. A burst is forwarded
// to the master only once its last beat is buffered, and whole bursts are
// forwarded one at a time. AR issue is gated by per-ID beat credits, so the
// queues cannot overflow while the slave honours the AXI protocol.
//
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   auto_in_ar{valid,ready,id,len}   AR from the master (only id/len used here)
//   auto_out_ar{valid,ready}         AR handshake towards the slave
//   auto_out_r*                      R beats from the slave (rready=1 outside reset)
//   auto_in_r*                       R beats to the master, whole bursts only
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no burst selected; pick the next completed burst round-robin
// LOCKED | streaming queue[lock_id] to the master until its last beat
module axi4_deinterleaver_pq #(
  parameter int ID_BITS   = 3,
  parameter int DATA_BITS = 64,
  parameter int ECHO_BITS = 7,
  parameter int BEATS     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 auto_in_arvalid,
  output logic                 auto_in_arready,
  input  logic [ID_BITS-1:0]   auto_in_arid,
  input  logic [7:0]           auto_in_arlen,
  output logic                 auto_out_arvalid,
  input  logic                 auto_out_arready,
  input  logic                 auto_out_rvalid,
  output logic                 auto_out_rready,
  input  logic [ID_BITS-1:0]   auto_out_rid,
  input  logic [DATA_BITS-1:0] auto_out_rdata,
  input  logic [ECHO_BITS-1:0] auto_out_recho,
  input  logic                 auto_out_rlast,
  output logic                 auto_in_rvalid,
  input  logic                 auto_in_rready,
  output logic [ID_BITS-1:0]   auto_in_rid,
  output logic [DATA_BITS-1:0] auto_in_rdata,
  output logic [ECHO_BITS-1:0] auto_in_recho,
  output logic                 auto_in_rlast
);
  localparam int NIDS = 1 << ID_BITS;
  localparam int EW   = DATA_BITS + ECHO_BITS + 1;
  localparam int CW   = $clog2(BEATS + 1);
  localparam int PW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ID_BITS-1:0] lock_id_q, lock_id_d;
  logic [ID_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      res_q  [NIDS];
  logic [CW-1:0]      res_d  [NIDS];
  logic [CW-1:0]      pend_q [NIDS];
  logic [CW-1:0]      pend_d [NIDS];
  logic [CW-1:0]      cnt_q  [NIDS];
  logic [CW-1:0]      cnt_d  [NIDS];
  logic [PW-1:0]      wr_q   [NIDS];
  logic [PW-1:0]      wr_d   [NIDS];
  logic [PW-1:0]      rd_q   [NIDS];
  logic [PW-1:0]      rd_d   [NIDS];
  logic [EW-1:0]      mem_q  [NIDS][BEATS];
  logic [EW-1:0]      mem_d  [NIDS][BEATS];

  logic               r_push, r_pop, ar_ok, ar_fire;
  logic [8:0]         res_eff, ar_need;
  logic [EW-1:0]      head;
  logic               grant_found;
  logic [ID_BITS-1:0] grant_id, cand;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BEATS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head            = mem_q[lock_id_q][rd_q[lock_id_q]];
  assign auto_in_rvalid  = !reset && (state_q == S_LOCKED) && (cnt_q[lock_id_q] != '0);
  assign auto_in_rid     = lock_id_q;
  assign {auto_in_rdata, auto_in_recho, auto_in_rlast} = head;
  assign r_pop           = auto_in_rvalid && auto_in_rready;
  assign auto_out_rready = !reset;
  // A push into a full queue is a slave protocol error; the beat is dropped.
  assign r_push          = auto_out_rvalid && !reset && (cnt_q[auto_out_rid] != CW'(BEATS));

  // A beat delivered this cycle returns its credit immediately, so a waiting
  // AR on the same ID can be accepted in that very cycle.
  assign res_eff = 9'(res_q[auto_in_arid])
                 - ((r_pop && (lock_id_q == auto_in_arid)) ? 9'd1 : 9'd0);
  assign ar_need = res_eff + {1'b0, auto_in_arlen} + 9'd1;
  assign ar_ok   = (ar_need <= 9'(BEATS));

  assign auto_out_arvalid = !reset && auto_in_arvalid && ar_ok;
  assign auto_in_arready  = !reset && auto_out_arready && ar_ok;
  assign ar_fire          = auto_out_arvalid && auto_out_arready;

  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    rr_ptr_d    = rr_ptr_q;
    res_d       = res_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    mem_d       = mem_q;
    grant_found = 1'b0;
    grant_id    = rr_ptr_q;
    cand        = '0;

    if (ar_fire) res_d[auto_in_arid] = res_d[auto_in_arid] + CW'(auto_in_arlen) + CW'(1);
    if (r_pop)   res_d[lock_id_q]    = res_d[lock_id_q] - CW'(1);

    if (r_push) begin
      mem_d[auto_out_rid][wr_q[auto_out_rid]] = {auto_out_rdata, auto_out_recho, auto_out_rlast};
      wr_d[auto_out_rid]  = ptr_inc(wr_q[auto_out_rid]);
      cnt_d[auto_out_rid] = cnt_d[auto_out_rid] + CW'(1);
      if (auto_out_rlast) pend_d[auto_out_rid] = pend_d[auto_out_rid] + CW'(1);
    end

    if (r_pop) begin
      rd_d[lock_id_q]  = ptr_inc(rd_q[lock_id_q]);
      cnt_d[lock_id_q] = cnt_d[lock_id_q] - CW'(1);
      if (auto_in_rlast) pend_d[lock_id_q] = pend_d[lock_id_q] - CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        // Search starts one past the last grant; k = NIDS wraps to rr_ptr itself.
        for (int k = 1; k <= NIDS; k++) begin
          cand = rr_ptr_q + ID_BITS'(k);
          if (!grant_found && (pend_q[cand] != '0)) begin
            grant_found = 1'b1;
            grant_id    = cand;
          end
        end
        if (grant_found) begin
          state_d   = S_LOCKED;
          lock_id_d = grant_id;
          rr_ptr_d  = grant_id;
        end
      end
      S_LOCKED: begin
        if (r_pop && auto_in_rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= ID_BITS'(NIDS - 1);
      for (int i = 0; i < NIDS; i++) begin
        res_q[i]  <= '0;
        pend_q[i] <= '0;
        cnt_q[i]  <= '0;
        wr_q[i]   <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      res_q     <= res_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  // Queue storage needs no reset: occupancy counters define what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(auto_out_rvalid && (cnt_q[auto_out_rid] == CW'(BEATS))));

endmodule

// File: tb/tb_axi4_deinterleaver_pq.sv
module tb_axi4_deinterleaver_pq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_arvalid = 1'b0, in_arready;
  logic [2:0]  in_arid = '0;
  logic [7:0]  in_arlen = '0;
  logic        out_arvalid, out_arready = 1'b0;
  logic        out_rvalid = 1'b0, out_rready;
  logic [2:0]  out_rid = '0;
  logic [63:0] out_rdata = '0;
  logic [6:0]  out_recho = '0;
  logic        out_rlast = 1'b0;
  logic        in_rvalid, in_rready = 1'b0;
  logic [2:0]  in_rid;
  logic [63:0] in_rdata;
  logic [6:0]  in_recho;
  logic        in_rlast;

  axi4_deinterleaver_pq dut (
    .clock(clock), .reset(reset),
    .auto_in_arvalid(in_arvalid), .auto_in_arready(in_arready),
    .auto_in_arid(in_arid), .auto_in_arlen(in_arlen),
    .auto_out_arvalid(out_arvalid), .auto_out_arready(out_arready),
    .auto_out_rvalid(out_rvalid), .auto_out_rready(out_rready),
    .auto_out_rid(out_rid), .auto_out_rdata(out_rdata),
    .auto_out_recho(out_recho), .auto_out_rlast(out_rlast),
    .auto_in_rvalid(in_rvalid), .auto_in_rready(in_rready),
    .auto_in_rid(in_rid), .auto_in_rdata(in_rdata),
    .auto_in_recho(in_recho), .auto_in_rlast(in_rlast)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  id;
    logic [63:0] data;
    logic [6:0]  echo;
    logic        last;
  } beat_t;

  typedef struct {
    logic [2:0] id;
    logic [7:0] len;
    logic       ardy;
    logic       exp_ok;
  } ar_vec_t;

  beat_t   exp_q[$];
  int      exp_order[$];
  int      fire_cyc[$];
  ar_vec_t tbl[13];

  logic         mon_pv = 1'b0;
  logic [74:0]  mon_pp = '0;
  logic         mon_burst = 1'b0;
  logic [2:0]   mon_cur = '0;
  int           mon_found;
  logic         accepted;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [2:0] rid, input logic [63:0] d,
                       input logic last, input logic av, input logic [2:0] aid,
                       input logic [7:0] alen, input logic ardy, input logic rrdy);
    beat_t b;
    @(negedge clock);
    out_rvalid  = rv;
    out_rid     = rid;
    out_rdata   = d;
    out_recho   = d[10:4];
    out_rlast   = last;
    in_arvalid  = av;
    in_arid     = aid;
    in_arlen    = alen;
    out_arready = ardy;
    in_rready   = rrdy;
    if (rv) begin
      b.id = rid; b.data = d; b.echo = d[10:4]; b.last = last;
      exp_q.push_back(b);
    end
    #1;
  endtask

  task automatic idle(input logic rrdy);
    drive(1'b0, 3'd0, 64'd0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1, rrdy);
  endtask

  task automatic ar(input logic [2:0] aid, input logic [7:0] alen, input logic rrdy);
    drive(1'b0, 3'd0, 64'd0, 1'b0, 1'b1, aid, alen, 1'b1, rrdy);
  endtask

  task automatic beat(input logic [2:0] rid, input logic [63:0] d, input logic last,
                      input logic rrdy);
    drive(1'b1, rid, d, last, 1'b0, 3'd0, 8'd0, 1'b1, rrdy);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b1;
    in_arvalid  = 1'b1;
    in_arid     = 3'd0;
    in_arlen    = 8'd0;
    out_arready = 1'b1;
    out_rvalid  = 1'b0;
    in_rready   = 1'b1;
    #1;
    chk("rst_in_arready",  128'(in_arready),  128'(0));
    chk("rst_out_arvalid", 128'(out_arvalid), 128'(0));
    chk("rst_out_rready",  128'(out_rready),  128'(0));
    chk("rst_in_rvalid",   128'(in_rvalid),   128'(0));
    @(negedge clock);
    reset      = 1'b0;
    in_arvalid = 1'b0;
    exp_q.delete();
    exp_order.delete();
    fire_cyc.delete();
    #1;
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    while ((exp_q.size() != 0 || exp_order.size() != 0) && k < max_cyc) begin
      idle(1'b1);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0 || exp_order.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats and %0d bursts still outstanding, required 0",
               exp_q.size(), exp_order.size());
    end
  endtask

  // Monitor / scoreboard: burst order from exp_order, beat payloads per ID
  // from exp_q, plus AXI hold/stability rules on the master R channel.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        mon_pv    = 1'b0;
        mon_burst = 1'b0;
      end else begin
        if (mon_pv) begin
          chk("hold_rvalid",  128'(in_rvalid), 128'(1));
          chk("hold_payload", 128'({in_rid, in_rdata, in_recho, in_rlast}), 128'(mon_pp));
        end
        if (out_arvalid) chk("ar_len_limit", 128'(in_arlen < 8'd4), 128'(1));
        if (in_rvalid && in_rready) begin
          fire_cyc.push_back(cyc);
          if (!mon_burst) begin
            if (exp_order.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL burst_start: got unexpected burst rid=%0d, required none", in_rid);
            end else begin
              chk("burst_id", 128'(in_rid), 128'(exp_order.pop_front()));
            end
            mon_burst = 1'b1;
            mon_cur   = in_rid;
          end else begin
            chk("no_interleave", 128'(in_rid), 128'(mon_cur));
          end
          mon_found = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (mon_found < 0 && exp_q[k].id == in_rid) mon_found = k;
          if (mon_found < 0) begin
            n_tests++; n_fail++;
            $display("FAIL beat_present: got beat rid=%0d data=%0h, required none", in_rid, in_rdata);
          end else begin
            chk("beat_payload", 128'({in_rdata, in_recho, in_rlast}),
                128'({exp_q[mon_found].data, exp_q[mon_found].echo, exp_q[mon_found].last}));
            exp_q.delete(mon_found);
          end
          if (in_rlast) mon_burst = 1'b0;
        end
        mon_pv = in_rvalid && !in_rready;
        mon_pp = {in_rid, in_rdata, in_recho, in_rlast};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // AR credit table, applied in order from an empty reset state (BEATS=4).
    tbl[0]  = '{3'd0, 8'd1,   1'b1, 1'b1};  // res0 -> 2
    tbl[1]  = '{3'd0, 8'd1,   1'b0, 1'b1};  // slave not ready: no fire
    tbl[2]  = '{3'd0, 8'd1,   1'b1, 1'b1};  // res0 -> 4
    tbl[3]  = '{3'd0, 8'd0,   1'b1, 1'b0};
    tbl[4]  = '{3'd1, 8'd3,   1'b1, 1'b1};  // res1 -> 4
    tbl[5]  = '{3'd2, 8'd4,   1'b1, 1'b0};  // 5 beats can never fit
    tbl[6]  = '{3'd2, 8'd255, 1'b1, 1'b0};  // no wrap at 8 bits
    tbl[7]  = '{3'd7, 8'd3,   1'b1, 1'b1};
    tbl[8]  = '{3'd7, 8'd0,   1'b1, 1'b0};
    tbl[9]  = '{3'd3, 8'd2,   1'b1, 1'b1};  // res3 -> 3
    tbl[10] = '{3'd3, 8'd0,   1'b1, 1'b1};  // res3 -> 4, exactly full
    tbl[11] = '{3'd3, 8'd0,   1'b1, 1'b0};
    tbl[12] = '{3'd6, 8'd0,   1'b1, 1'b1};

    do_reset();
    idle(1'b1);
    chk("post_rst_rready", 128'(out_rready), 128'(1));
    chk("post_rst_rvalid", 128'(in_rvalid),  128'(0));

    foreach (tbl[i]) begin
      drive(1'b0, 3'd0, 64'd0, 1'b0, 1'b1, tbl[i].id, tbl[i].len, tbl[i].ardy, 1'b1);
      chk($sformatf("tbl%0d_out_arvalid", i), 128'(out_arvalid), 128'(tbl[i].exp_ok));
      chk($sformatf("tbl%0d_in_arready", i),  128'(in_arready),  128'(tbl[i].exp_ok & tbl[i].ardy));
    end
    idle(1'b1);
    chk("tbl_no_rvalid", 128'(in_rvalid), 128'(0));

    // Single burst: latency t+2 and back-to-back beats, credit returned.
    do_reset();
    ar(3'd2, 8'd3, 1'b1);
    chk("single_ar", 128'(in_arready), 128'(1));
    exp_order.push_back(2);
    for (int k = 0; k < 4; k++) beat(3'd2, 64'hD0 + 64'(k), (k == 3), 1'b1);
    idle(1'b1);
    chk("single_lat_t1", 128'(in_rvalid), 128'(0));
    idle(1'b1);
    chk("single_lat_t2", 128'(in_rvalid), 128'(1));
    drain(20);
    chk("single_span", 128'(fire_cyc.size() == 4 ? fire_cyc[3] - fire_cyc[0] : -1), 128'(3));
    ar(3'd2, 8'd3, 1'b1);
    chk("single_res_free", 128'(in_arready), 128'(1));

    // Interleaved bursts on ids 1 and 5 come out whole, one bubble between.
    do_reset();
    ar(3'd1, 8'd1, 1'b1);
    chk("il_ar1", 128'(in_arready), 128'(1));
    ar(3'd5, 8'd1, 1'b1);
    chk("il_ar5", 128'(in_arready), 128'(1));
    exp_order.push_back(1);
    exp_order.push_back(5);
    beat(3'd1, 64'hA0, 1'b0, 1'b1);
    beat(3'd5, 64'hB0, 1'b0, 1'b1);
    beat(3'd1, 64'hA1, 1'b1, 1'b1);
    beat(3'd5, 64'hB1, 1'b1, 1'b1);
    drain(30);
    chk("il_a_b2b",  128'(fire_cyc.size() == 4 ? fire_cyc[1] - fire_cyc[0] : -1), 128'(1));
    chk("il_bubble", 128'(fire_cyc.size() == 4 ? fire_cyc[2] - fire_cyc[1] : -1), 128'(2));

    // Credit: second AR on id3 accepted exactly when the first beat is delivered.
    do_reset();
    ar(3'd3, 8'd3, 1'b1);
    chk("cr_first_ar", 128'(in_arready), 128'(1));
    exp_order.push_back(3);
    accepted = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive((k < 4), 3'd3, 64'hC0 + 64'(k), (k == 3), !accepted, 3'd3, 8'd0, 1'b1, 1'b1);
      if (!accepted) begin
        chk($sformatf("cr_arready_c%0d", k), 128'(in_arready), 128'(k == 5));
        if (in_arready) accepted = 1'b1;
      end
    end
    chk("cr_accepted", 128'(accepted), 128'(1));
    drain(20);

    // Round-robin from rr_ptr=7: 0,4,7 then a fresh id0 burst after 7.
    do_reset();
    ar(3'd0, 8'd0, 1'b0);
    ar(3'd4, 8'd0, 1'b0);
    ar(3'd7, 8'd0, 1'b0);
    chk("rr_ar7", 128'(in_arready), 128'(1));
    exp_order.push_back(0);
    exp_order.push_back(4);
    exp_order.push_back(7);
    exp_order.push_back(0);
    beat(3'd0, 64'h100, 1'b1, 1'b0);
    beat(3'd4, 64'h400, 1'b1, 1'b0);
    beat(3'd7, 64'h700, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("rr_first_rid", 128'(in_rid), 128'(0));
    idle(1'b1);
    ar(3'd0, 8'd0, 1'b1);
    chk("rr_ar0_again", 128'(in_arready), 128'(1));
    beat(3'd0, 64'h101, 1'b1, 1'b1);
    drain(30);

    // Backpressure mid-burst on id1 while id6 completes.
    do_reset();
    ar(3'd1, 8'd3, 1'b1);
    ar(3'd6, 8'd0, 1'b1);
    chk("bp_ar6", 128'(in_arready), 128'(1));
    exp_order.push_back(1);
    exp_order.push_back(6);
    for (int k = 0; k < 4; k++) beat(3'd1, 64'hE000 + 64'(k), (k == 3), 1'b1);
    idle(1'b1);
    idle(1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) beat(3'd6, 64'hF000, 1'b1, 1'b0);
      else        idle(1'b0);
      chk($sformatf("bp_rvalid_s%0d", k), 128'(in_rvalid), 128'(1));
      chk($sformatf("bp_rdata_s%0d", k),  128'(in_rdata),  128'(64'hE001));
    end
    drain(30);

    // Reset while LOCKED discards everything.
    do_reset();
    ar(3'd2, 8'd3, 1'b0);
    for (int k = 0; k < 4; k++) beat(3'd2, 64'h5000 + 64'(k), (k == 3), 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("mr_locked_rvalid", 128'(in_rvalid), 128'(1));
    do_reset();
    chk("mr_rvalid_after", 128'(in_rvalid), 128'(0));
    ar(3'd0, 8'd0, 1'b1);
    chk("mr_ar0", 128'(in_arready), 128'(1));
    ar(3'd2, 8'd3, 1'b1);
    chk("mr_ar2_res_clear", 128'(in_arready), 128'(1));
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      chk($sformatf("mr_quiet%0d", k), 128'(in_rvalid), 128'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
